// File: rtl/pcie_x1_evt_cnt_pkg.sv
// Shared constants for the PCIe x1 event counter block: parameter defaults and
// the channel index of each event source, so the top and the register map agree.
package pcie_x1_evt_cnt_pkg;

  localparam int unsigned CntWDef   = 16;
  localparam int unsigned SelWDef   = 4;
  localparam int unsigned ThreshDef = 32'h0000_0100;

  // Channel assignment of the synchronized event sources.
  localparam int unsigned ChLtssmRecov = 0;
  localparam int unsigned ChBadTlp     = 1;
  localparam int unsigned ChBadDllp    = 2;
  localparam int unsigned ChReplayTo   = 3;

  // True when a read index addresses an implemented channel.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned width);
    return sel < width;
  endfunction

endpackage

// File: rtl/pcie_x1_evt_chan.sv
// One event channel: rising-edge detect, saturating counter with clear port,
// and a sticky threshold flag.
module pcie_x1_evt_chan
  import pcie_x1_evt_cnt_pkg::*;
#(
  parameter int unsigned CNT_W  = CntWDef,
  parameter int unsigned THRESH = ThreshDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_i,
  input  logic             clr_i,
  input  logic             thr_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             thr_flag_o
);

  localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

  logic             evt_q;
  logic             rise;
  logic             inc;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  // Next-state: clear is applied first so a same-cycle rise lands on zero and is kept.
  always_comb begin
    rise   = evt_i & ~evt_q;
    base   = clr_i ? '0 : cnt_q;
    inc    = rise & (base != '1);
    cnt_d  = inc ? base + CNT_W'(1) : base;
    // Only an actual increment can set the flag; set wins over clear.
    flag_d = (inc & (cnt_d >= ThreshVal)) | (flag_q & ~thr_clr_i);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q  <= 1'b0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      evt_q  <= evt_i;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign thr_flag_o = flag_q;

endmodule

// File: rtl/pcie_x1_evt_cnt.sv
// PCIe x1 slow-domain event counters: per-channel counters, a pipelined
// software read port with optional clear-on-read, and a threshold interrupt.
module pcie_x1_evt_cnt
  import pcie_x1_evt_cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned CNT_W  = CntWDef,
  parameter int unsigned THRESH = ThreshDef,
  parameter int unsigned SEL_W  = SelWDef
) (
  input  logic             s_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] evt_sclk,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             rd_clr,
  output logic             rd_vld,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_err,
  output logic [WIDTH-1:0] thr_flag,
  input  logic [WIDTH-1:0] thr_clr,
  output logic             irq
);

  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0]            chan_clr;
  logic                        sel_ok;
  logic [CNT_W-1:0]            sel_cnt;

  logic             rd_vld_q, rd_vld_d;
  logic             rd_err_q, rd_err_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             irq_q, irq_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    localparam logic [SEL_W-1:0] Idx = SEL_W'(i);

    assign chan_clr[i] = rd_en & rd_clr & (rd_sel == Idx);

    pcie_x1_evt_chan #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
    ) u_chan (
      .clk_i      (s_clk),
      .rst_i      (rst),
      .evt_i      (evt_sclk[i]),
      .clr_i      (chan_clr[i]),
      .thr_clr_i  (thr_clr[i]),
      .cnt_o      (cnt[i]),
      .thr_flag_o (thr_flag[i])
    );
  end

  // Read mux and response next-state; out-of-range reads return zero with rd_err.
  always_comb begin
    sel_ok  = sel_in_range(32'(rd_sel), WIDTH);
    sel_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_sel == SEL_W'(i)) sel_cnt = cnt[i];
    end
    rd_vld_d  = rd_en;
    rd_err_d  = rd_en & ~sel_ok;
    rd_data_d = rd_en ? (sel_ok ? sel_cnt : '0) : rd_data_q;
    irq_d     = |thr_flag;
  end

  // Read response and interrupt registers; reset drops any in-flight read.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_err  = rd_err_q;
  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule
